// File: rtl/chipper_pkg.sv
// Shared definitions for the pipelined deflection router: port indices and
// flit field accessors that work for any flit geometry up to MAXW bits.
package chipper_pkg;

    localparam int MAXW    = 64;
    localparam int FIELD_W = 16;

    localparam int PORT_N = 0;
    localparam int PORT_S = 1;
    localparam int PORT_E = 2;
    localparam int PORT_W = 3;

    // Layout, MSB to LSB: valid, dst_x, dst_y, seq, payload
    function automatic int dx_lsb(input int flit_w, input int xw);
        return flit_w - 1 - xw;
    endfunction

    function automatic int dy_lsb(input int flit_w, input int xw, input int yw);
        return flit_w - 1 - xw - yw;
    endfunction

    function automatic int seq_lsb(input int flit_w, input int xw, input int yw,
                                   input int seq_w);
        return flit_w - 1 - xw - yw - seq_w;
    endfunction

    function automatic logic [FIELD_W-1:0] flit_field(input logic [MAXW-1:0] f,
                                                      input int lsb, input int w);
        logic [MAXW-1:0] t;
        t = (f >> lsb) & ((MAXW'(1) << w) - MAXW'(1));
        return t[FIELD_W-1:0];
    endfunction

    function automatic logic flit_valid(input logic [MAXW-1:0] f, input int flit_w);
        return f[flit_w-1];
    endfunction

    function automatic logic [FIELD_W-1:0] flit_dst_x(input logic [MAXW-1:0] f,
                                                      input int flit_w, input int xw);
        return flit_field(f, dx_lsb(flit_w, xw), xw);
    endfunction

    function automatic logic [FIELD_W-1:0] flit_dst_y(input logic [MAXW-1:0] f,
                                                      input int flit_w, input int xw,
                                                      input int yw);
        return flit_field(f, dy_lsb(flit_w, xw, yw), yw);
    endfunction

    function automatic logic [FIELD_W-1:0] flit_seq(input logic [MAXW-1:0] f,
                                                    input int flit_w, input int xw,
                                                    input int yw, input int seq_w);
        return flit_field(f, seq_lsb(flit_w, xw, yw, seq_w), seq_w);
    endfunction

endpackage

// File: rtl/chipper_permute.sv
// Combinational port allocator: golden flits first, then round-robin from rr;
// a flit that loses its productive port is deflected to the first free of N,E,S,W.
module chipper_permute
    import chipper_pkg::*;
#(
    parameter int FLIT_W = 16,
    parameter int XW     = 2,
    parameter int YW     = 2,
    parameter int SEQ_W  = 3,
    parameter int X_ID   = 0,
    parameter int Y_ID   = 0
) (
    input  logic [3:0][FLIT_W-1:0] slot,
    input  logic [SEQ_W-1:0]       golden_id,
    input  logic [1:0]             rr,
    output logic [3:0][FLIT_W-1:0] port_out,
    output logic [2:0]             defl
);

    localparam logic [2:0] NONE = 3'd4;
    localparam logic [3:0][1:0] FALLBACK = {2'(PORT_W), 2'(PORT_S), 2'(PORT_E), 2'(PORT_N)};

    logic [3:0]      valid;
    logic [3:0]      gold;
    logic [3:0][2:0] prod;
    logic [3:0]      taken;
    logic [1:0]      sel;
    logic [2:0]      want;
    logic            placed;

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            valid[i] = flit_valid(MAXW'(slot[i]), FLIT_W);
            gold[i]  = valid[i] &&
                       (flit_seq(MAXW'(slot[i]), FLIT_W, XW, YW, SEQ_W) == FIELD_W'(golden_id));
            if (int'(flit_dst_x(MAXW'(slot[i]), FLIT_W, XW)) > X_ID)
                prod[i] = 3'(PORT_E);
            else if (int'(flit_dst_x(MAXW'(slot[i]), FLIT_W, XW)) < X_ID)
                prod[i] = 3'(PORT_W);
            else if (int'(flit_dst_y(MAXW'(slot[i]), FLIT_W, XW, YW)) > Y_ID)
                prod[i] = 3'(PORT_N);
            else if (int'(flit_dst_y(MAXW'(slot[i]), FLIT_W, XW, YW)) < Y_ID)
                prod[i] = 3'(PORT_S);
            else
                prod[i] = NONE;
        end
    end

    // Pass 0 places golden flits, pass 1 the rest; both walk slots from rr.
    always_comb begin
        port_out = '0;
        taken    = '0;
        defl     = '0;
        sel      = '0;
        want     = NONE;
        placed   = 1'b0;
        for (int pass = 0; pass < 2; pass++) begin
            for (int i = 0; i < 4; i++) begin
                sel = rr + 2'(i);
                if (valid[sel] && (gold[sel] == (pass == 0))) begin
                    want = prod[sel];
                    if (want != NONE && !taken[want[1:0]]) begin
                        port_out[want[1:0]] = slot[sel];
                        taken[want[1:0]]    = 1'b1;
                    end else begin
                        defl   = defl + 3'd1;
                        placed = 1'b0;
                        for (int k = 0; k < 4; k++) begin
                            if (!placed && !taken[FALLBACK[k]]) begin
                                port_out[FALLBACK[k]] = slot[sel];
                                taken[FALLBACK[k]]    = 1'b1;
                                placed                = 1'b1;
                            end
                        end
                    end
                end
            end
        end
    end

endmodule

// File: rtl/chipper_pipe_router.sv
// Two-stage bufferless deflection router node: eject/inject into stage-A slots,
// then permute onto registered link outputs, with golden rotation and deflection count.
module chipper_pipe_router
    import chipper_pkg::*;
#(
    parameter int FLIT_W       = 16,
    parameter int XW           = 2,
    parameter int YW           = 2,
    parameter int SEQ_W        = 3,
    parameter int X_ID         = 0,
    parameter int Y_ID         = 0,
    parameter int GOLDEN_EPOCH = 64,
    parameter int CNT_W        = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [FLIT_W-1:0] nin,
    input  logic [FLIT_W-1:0] sin,
    input  logic [FLIT_W-1:0] ein,
    input  logic [FLIT_W-1:0] win,
    input  logic [FLIT_W-1:0] lin,
    output logic              lin_ready,
    output logic [FLIT_W-1:0] nout,
    output logic [FLIT_W-1:0] sout,
    output logic [FLIT_W-1:0] eout,
    output logic [FLIT_W-1:0] wout,
    output logic [FLIT_W-1:0] lout,
    output logic [SEQ_W-1:0]  golden_id,
    output logic [CNT_W-1:0]  defl_cnt,
    input  logic              defl_clr
);

    localparam int EW = $clog2(GOLDEN_EPOCH);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [3:0][FLIT_W-1:0] link_in;
    logic [3:0][FLIT_W-1:0] slot_nxt;
    logic [3:0][FLIT_W-1:0] slot_a;
    logic [3:0][FLIT_W-1:0] perm_out;
    logic [3:0]             in_valid;
    logic [3:0]             in_local;
    logic [3:0]             in_gold;
    logic [3:0]             slot_free;
    logic                   ej_hit;
    logic [1:0]             ej_sel;
    logic [1:0]             ins_sel;
    logic [FLIT_W-1:0]      lout_nxt;
    logic [2:0]             perm_defl;
    logic [1:0]             rr;
    logic [EW-1:0]          epoch;
    logic [CNT_W+2:0]       defl_sum;

    assign link_in = {win, ein, sin, nin};

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            in_valid[i] = flit_valid(MAXW'(link_in[i]), FLIT_W);
            in_local[i] = in_valid[i] &&
                          (int'(flit_dst_x(MAXW'(link_in[i]), FLIT_W, XW)) == X_ID) &&
                          (int'(flit_dst_y(MAXW'(link_in[i]), FLIT_W, XW, YW)) == Y_ID);
            in_gold[i]  = in_valid[i] &&
                          (flit_seq(MAXW'(link_in[i]), FLIT_W, XW, YW, SEQ_W) == FIELD_W'(golden_id));
        end
    end

    // Lowest local slot wins, unless some local slot is golden (lowest golden then wins).
    always_comb begin
        ej_hit = 1'b0;
        ej_sel = '0;
        for (int i = 3; i >= 0; i--) begin
            if (in_local[i]) begin
                ej_hit = 1'b1;
                ej_sel = 2'(i);
            end
        end
        for (int i = 3; i >= 0; i--) begin
            if (in_local[i] && in_gold[i])
                ej_sel = 2'(i);
        end
    end

    assign lout_nxt = ej_hit ? link_in[ej_sel] : '0;

    // Invalid inputs are stored as all-zero so an empty slot never carries stale bits.
    always_comb begin
        slot_nxt  = '0;
        slot_free = '0;
        ins_sel   = '0;
        for (int i = 0; i < 4; i++) begin
            if (in_valid[i] && !(ej_hit && ej_sel == 2'(i)))
                slot_nxt[i] = link_in[i];
        end
        for (int i = 0; i < 4; i++)
            slot_free[i] = !slot_nxt[i][FLIT_W-1];
        for (int i = 3; i >= 0; i--) begin
            if (slot_free[i])
                ins_sel = 2'(i);
        end
        if (lin[FLIT_W-1] && (|slot_free))
            slot_nxt[ins_sel] = lin;
    end

    assign lin_ready = rst_n & (|slot_free);

    chipper_permute #(
        .FLIT_W (FLIT_W),
        .XW     (XW),
        .YW     (YW),
        .SEQ_W  (SEQ_W),
        .X_ID   (X_ID),
        .Y_ID   (Y_ID)
    ) u_permute (
        .slot      (slot_a),
        .golden_id (golden_id),
        .rr        (rr),
        .port_out  (perm_out),
        .defl      (perm_defl)
    );

    assign defl_sum = (CNT_W+3)'(defl_cnt) + (CNT_W+3)'(perm_defl);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_a    <= '0;
            lout      <= '0;
            nout      <= '0;
            sout      <= '0;
            eout      <= '0;
            wout      <= '0;
            rr        <= '0;
            epoch     <= '0;
            golden_id <= '0;
            defl_cnt  <= '0;
        end else begin
            slot_a <= slot_nxt;
            lout   <= lout_nxt;
            nout   <= perm_out[PORT_N];
            sout   <= perm_out[PORT_S];
            eout   <= perm_out[PORT_E];
            wout   <= perm_out[PORT_W];
            rr     <= rr + 2'd1;
            if (epoch == EW'(GOLDEN_EPOCH - 1)) begin
                epoch     <= '0;
                golden_id <= golden_id + 1'b1;
            end else begin
                epoch <= epoch + 1'b1;
            end
            if (defl_clr)
                defl_cnt <= '0;
            else if (defl_sum > {3'b000, CNT_MAX})
                defl_cnt <= CNT_MAX;
            else
                defl_cnt <= defl_sum[CNT_W-1:0];
        end
    end

endmodule

// File: tb/tb_chipper_pipe_router.sv
// Directed and randomized bench for chipper_pipe_router at node (1,1), with a
// queue-based reference model of ejection, injection and deflection routing.
module tb_chipper_pipe_router;

    localparam int FW = 16;
    localparam int X_ID = 1;
    localparam int Y_ID = 1;
    localparam int GE = 4;
    localparam int CW = 3;
    localparam int CMAX = 7;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [FW-1:0] nin = '0, sin = '0, ein = '0, win = '0, lin = '0;
    logic          defl_clr = 1'b0;
    logic          lin_ready;
    logic [FW-1:0] nout, sout, eout, wout, lout;
    logic [2:0]    golden_id;
    logic [CW-1:0] defl_cnt;

    int n_cmp = 0;
    int n_fail = 0;

    // reference model state
    logic [FW-1:0] m_a[4];
    logic [FW-1:0] m_out[4];
    logic [FW-1:0] m_lout;
    int            m_gold, m_epoch, m_rr, m_defl;
    logic [FW-1:0] s1_a[4];
    logic [FW-1:0] s1_lout;
    bit            s1_ready;
    logic [FW-1:0] r_out[4];
    int            r_defl;

    chipper_pipe_router #(
        .FLIT_W(FW), .XW(2), .YW(2), .SEQ_W(3), .X_ID(X_ID), .Y_ID(Y_ID),
        .GOLDEN_EPOCH(GE), .CNT_W(CW)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .nin(nin), .sin(sin), .ein(ein), .win(win), .lin(lin),
        .lin_ready(lin_ready),
        .nout(nout), .sout(sout), .eout(eout), .wout(wout), .lout(lout),
        .golden_id(golden_id), .defl_cnt(defl_cnt), .defl_clr(defl_clr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [FW-1:0] mk(input int dx, input int dy, input int sq, input int pay);
        logic [FW-1:0] f;
        f = {1'b1, 2'(dx), 2'(dy), 3'(sq), 8'(pay)};
        return f;
    endfunction

    function automatic bit is_local(input logic [FW-1:0] f);
        return f[15] && int'(f[14:13]) == X_ID && int'(f[12:11]) == Y_ID;
    endfunction

    function automatic bit is_gold(input logic [FW-1:0] f, input int g);
        return f[15] && int'(f[10:8]) == g;
    endfunction

    // 0=N 1=S 2=E 3=W, -1 when the flit is already home
    function automatic int prod_port(input logic [FW-1:0] f);
        int dx, dy;
        dx = int'(f[14:13]);
        dy = int'(f[12:11]);
        if (dx > X_ID) return 2;
        if (dx < X_ID) return 3;
        if (dy > Y_ID) return 0;
        if (dy < Y_ID) return 1;
        return -1;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            m_a[i] = '0;
            m_out[i] = '0;
        end
        m_lout = '0;
        m_gold = 0;
        m_epoch = 0;
        m_rr = 0;
        m_defl = 0;
    endtask

    task automatic model_stage1();
        logic [FW-1:0] f[4];
        int ej;
        bit done;
        f = '{nin, sin, ein, win};
        ej = -1;
        for (int i = 0; i < 4; i++)
            if (ej < 0 && is_local(f[i]) && is_gold(f[i], m_gold)) ej = i;
        for (int i = 0; i < 4; i++)
            if (ej < 0 && is_local(f[i])) ej = i;
        for (int i = 0; i < 4; i++)
            s1_a[i] = f[i][15] ? f[i] : '0;
        s1_lout = '0;
        if (ej >= 0) begin
            s1_lout = f[ej];
            s1_a[ej] = '0;
        end
        s1_ready = 0;
        for (int i = 0; i < 4; i++)
            if (!s1_a[i][15]) s1_ready = 1;
        if (lin[15]) begin
            done = 0;
            for (int i = 0; i < 4; i++)
                if (!done && !s1_a[i][15]) begin
                    s1_a[i] = lin;
                    done = 1;
                end
        end
    endtask

    task automatic model_route();
        int order[$];
        bit used[4];
        int fb[4] = '{0, 2, 1, 3};
        int s, p;
        bit done;
        r_defl = 0;
        for (int i = 0; i < 4; i++) begin
            r_out[i] = '0;
            used[i] = 0;
        end
        for (int i = 0; i < 4; i++) begin
            s = (m_rr + i) % 4;
            if (is_gold(m_a[s], m_gold)) order.push_back(s);
        end
        for (int i = 0; i < 4; i++) begin
            s = (m_rr + i) % 4;
            if (m_a[s][15] && !is_gold(m_a[s], m_gold)) order.push_back(s);
        end
        foreach (order[j]) begin
            s = order[j];
            p = prod_port(m_a[s]);
            if (p >= 0 && !used[p]) begin
                r_out[p] = m_a[s];
                used[p] = 1;
            end else begin
                r_defl++;
                done = 0;
                for (int k = 0; k < 4; k++)
                    if (!done && !used[fb[k]]) begin
                        r_out[fb[k]] = m_a[s];
                        used[fb[k]] = 1;
                        done = 1;
                    end
            end
        end
    endtask

    task automatic model_edge();
        model_route();
        model_stage1();
        for (int i = 0; i < 4; i++) begin
            m_out[i] = r_out[i];
            m_a[i] = s1_a[i];
        end
        m_lout = s1_lout;
        if (defl_clr) m_defl = 0;
        else m_defl = (m_defl + r_defl > CMAX) ? CMAX : m_defl + r_defl;
        m_epoch++;
        if (m_epoch == GE) begin
            m_epoch = 0;
            m_gold = (m_gold + 1) % 8;
        end
        m_rr = (m_rr + 1) % 4;
    endtask

    // inputs are already applied; check lin_ready, clock once, check registered outputs
    task automatic step();
        #1;
        model_stage1();
        chk("lin_ready", 32'(lin_ready), 32'(s1_ready));
        @(posedge clk);
        model_edge();
        @(negedge clk);
        chk("nout", 32'(nout), 32'(m_out[0]));
        chk("sout", 32'(sout), 32'(m_out[1]));
        chk("eout", 32'(eout), 32'(m_out[2]));
        chk("wout", 32'(wout), 32'(m_out[3]));
        chk("lout", 32'(lout), 32'(m_lout));
        chk("golden_id", 32'(golden_id), 32'(m_gold));
        chk("defl_cnt", 32'(defl_cnt), 32'(m_defl));
    endtask

    task automatic set_in(input logic [FW-1:0] n, input logic [FW-1:0] s,
                          input logic [FW-1:0] e, input logic [FW-1:0] w,
                          input logic [FW-1:0] l);
        nin = n; sin = s; ein = e; win = w; lin = l;
    endtask

    function automatic logic [FW-1:0] rnd_flit();
        int r;
        logic [FW-1:0] f;
        r = $urandom_range(0, 9);
        if (r < 6) begin
            if ($urandom_range(0, 3) == 0) f = mk(X_ID, Y_ID, $urandom_range(0, 7), $urandom_range(0, 255));
            else f = mk($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 7), $urandom_range(0, 255));
            if ($urandom_range(0, 3) == 0) f[10:8] = 3'(m_gold);
        end else if (r < 8) begin
            f = '0;
        end else begin
            f = 16'($urandom_range(0, 32767));
        end
        return f;
    endfunction

    initial begin
        logic [FW-1:0] fa, fb, gf, of;
        int gnext, dexp;
        model_reset();

        // reset state, lin_ready held low while in reset
        #21;
        chk("rst_lin_ready", 32'(lin_ready), 32'd0);
        chk("rst_outs", 32'(nout | sout | eout | wout | lout), 32'd0);
        chk("rst_golden", 32'(golden_id), 32'd0);
        chk("rst_defl", 32'(defl_cnt), 32'd0);
        #1 rst_n = 1'b1;

        // two golden local flits: lower slot ejects, the other is deflected to N
        fa = mk(1, 1, 0, 8'h11);
        fb = mk(1, 1, 0, 8'h22);
        set_in(fa, fb, '0, '0, '0);
        step();
        chk("eject_lout", 32'(lout), 32'(fa));
        set_in('0, '0, '0, '0, '0);
        step();
        chk("local_defl_nout", 32'(nout), 32'(fb));
        chk("local_defl_cnt", 32'(defl_cnt), 32'd1);
        chk("local_defl_lout", 32'(lout), 32'd0);

        // single flit from W heading east
        fa = mk(2, 1, 5, 8'h3C);
        set_in('0, '0, '0, fa, '0);
        step();
        set_in('0, '0, '0, '0, '0);
        step();
        chk("pass_eout", 32'(eout), 32'(fa));
        chk("pass_others", 32'(nout | sout | wout), 32'd0);
        chk("pass_defl", 32'(defl_cnt), 32'd1);

        // full links block injection, then a free slot admits lin
        set_in(mk(3, 1, 1, 1), mk(0, 1, 2, 2), mk(1, 3, 3, 3), mk(1, 0, 4, 4), mk(3, 3, 6, 8'h77));
        #1;
        chk("lin_ready_full", 32'(lin_ready), 32'd0);
        step();
        ein = '0;
        #1;
        chk("lin_ready_free", 32'(lin_ready), 32'd1);
        step();
        set_in('0, '0, '0, '0, '0);
        step();
        step();

        // golden flit wins the contested east port
        gnext = (m_epoch == GE - 1) ? (m_gold + 1) % 8 : m_gold;
        gf = mk(3, 1, gnext, 8'hA5);
        of = mk(3, 1, (gnext + 1) % 8, 8'h5A);
        set_in(of, '0, '0, gf, '0);
        step();
        dexp = (m_defl + 1 > CMAX) ? CMAX : m_defl + 1;
        set_in('0, '0, '0, '0, '0);
        step();
        chk("golden_eout", 32'(eout), 32'(gf));
        chk("golden_loser_nout", 32'(nout), 32'(of));
        chk("golden_defl", 32'(defl_cnt), 32'(dexp));

        // three deflections per cycle saturate the counter
        for (int c = 0; c < 3; c++) begin
            set_in(mk(3, 1, 1, c), mk(2, 0, 2, c), mk(3, 2, 3, c), mk(2, 3, 4, c), '0);
            step();
        end
        set_in('0, '0, '0, '0, '0);
        step();
        chk("defl_saturated", 32'(defl_cnt), 32'd7);

        // clear wins over deflections in the same cycle
        set_in(mk(3, 1, 1, 9), mk(2, 0, 2, 9), mk(3, 2, 3, 9), mk(2, 3, 4, 9), '0);
        step();
        set_in('0, '0, '0, '0, '0);
        defl_clr = 1'b1;
        step();
        defl_clr = 1'b0;
        chk("defl_clear", 32'(defl_cnt), 32'd0);

        // asynchronous reset in the middle of traffic
        set_in(mk(3, 1, 1, 1), mk(0, 1, 2, 2), mk(1, 3, 3, 3), mk(1, 0, 4, 4), '0);
        step();
        step();
        #2;
        set_in('0, '0, '0, '0, '0);
        rst_n = 1'b0;
        #1;
        chk("async_rst_outs", 32'(nout | sout | eout | wout | lout), 32'd0);
        chk("async_rst_ready", 32'(lin_ready), 32'd0);
        chk("async_rst_golden", 32'(golden_id), 32'd0);
        model_reset();
        @(negedge clk);
        #2 rst_n = 1'b1;

        // golden tag rotation including the 7 -> 0 wrap
        for (int k = 1; k <= 36; k++) begin
            step();
            if (k % 4 == 0)
                chk("golden_rotate", 32'(golden_id), 32'((k / 4) % 8));
        end
        chk("post_rst_quiet", 32'(nout | sout | eout | wout | lout), 32'd0);

        // randomized traffic against the reference model
        for (int c = 0; c < 400; c++) begin
            set_in(rnd_flit(), rnd_flit(), rnd_flit(), rnd_flit(), rnd_flit());
            defl_clr = ($urandom_range(0, 15) == 0);
            step();
        end
        defl_clr = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
